// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div and
// reports busy to the decode stall logic; serves mfhi/mflo read data.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       hi_nxt;
    logic [31:0]       lo_nxt;
    logic              wr_pend;

    logic              is_md_op;
    logic              is_div;
    logic              div_zero;
    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic [31:0]       a_abs;
    logic [31:0]       b_abs;
    logic [31:0]       sdiv_b;
    logic [31:0]       udiv_b;
    logic [31:0]       q_mag;
    logic [31:0]       r_mag;
    logic [31:0]       uq;
    logic [31:0]       ur;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;

    assign is_md_op = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                      (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign is_div   = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    assign div_zero = (rt_val == 32'd0);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide on magnitudes; divisor forced nonzero so the divider never sees 0.
    assign a_abs  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign b_abs  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign sdiv_b = b_abs  | {31'd0, div_zero};
    assign udiv_b = rt_val | {31'd0, div_zero};
    assign q_mag  = a_abs / sdiv_b;
    assign r_mag  = a_abs % sdiv_b;
    assign uq     = rs_val / udiv_b;
    assign ur     = rs_val % udiv_b;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (mdu_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_lo = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
                res_hi = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
            end
            OP_DIVU: begin
                res_lo = uq;
                res_hi = ur;
            end
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

    // Control FSM with the HI/LO architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_nxt  <= 32'd0;
            lo_nxt  <= 32'd0;
            wr_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !req && is_md_op) begin
                        hi_nxt  <= res_hi;
                        lo_nxt  <= res_lo;
                        wr_pend <= !(is_div && div_zero);
                        cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else if (!req && (mdu_op == OP_MTHI)) begin
                        hi <= rs_val;
                    end else if (!req && (mdu_op == OP_MTLO)) begin
                        lo <= rs_val;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (wr_pend) begin
                            hi <= hi_nxt;
                            lo <= lo_nxt;
                        end
                        wr_pend <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (mdu_op == OP_MFHI) begin
            rd_data = hi;
        end else if (mdu_op == OP_MFLO) begin
            rd_data = lo;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected HI/LO and busy length,
// a monitor checks them whenever busy falls.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;
    logic busy_prev = 1'b0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .req     (req),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic rq);
        @(posedge clk);
        #1;
        mdu_op = op;
        rs_val = a;
        rt_val = b;
        start  = st;
        req    = rq;
    endtask

    task automatic idle_in();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic rq);
        drive(op, a, b, st, rq);
        idle_in();
    endtask

    task automatic expect_op(input string nm, input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.name = nm;
        e.hi = h;
        e.lo = l;
        e.cycles = n;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s: busy still 1 after 40 cycles, expected 0", nm);
        end
        @(negedge clk);
    endtask

    // Monitor: a falling busy marks a retired op; compare against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            busy_prev <= 1'b0;
            busy_cnt  <= 0;
        end else begin
            if (busy) begin
                busy_cnt <= busy_cnt + 1;
            end else if (busy_prev) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_completion: got hi=%08h lo=%08h expected no op", hi, lo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
                end
                busy_cnt <= 0;
            end
            busy_prev <= busy;
        end
    end

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        mdu_op = 4'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        req    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;

        expect_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        wait_idle("mult_neg");

        expect_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_idle("multu_max");

        expect_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_idle("div_m7_2");

        expect_op("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd4, 32'd7, 32'd0, 1'b1, 1'b0);
        wait_idle("divu_by0");

        expect_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_idle("div_ovf");

        expect_op("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 10);
        issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        wait_idle("div_7_m2");

        // Start, mthi and mtlo while busy must all be ignored.
        expect_op("divu_overlap", 32'd2, 32'd14, 10);
        drive(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
        idle_in();
        drive(4'd4, 32'd9, 32'd2, 1'b1, 1'b0);
        drive(4'd7, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0);
        drive(4'd8, 32'h0000_BEEF, 32'd0, 1'b0, 1'b0);
        idle_in();
        wait_idle("divu_overlap");

        expect_op("mult_2p32", 32'h0000_0001, 32'h0000_0000, 5);
        issue(4'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        wait_idle("mult_2p32");

        issue(4'd7, 32'h0000_1234, 32'd0, 1'b0, 1'b1);
        chk("mthi_req_hi", hi, 32'h0000_0001);
        issue(4'd7, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        chk("mthi_hi", hi, 32'h0000_1234);
        mdu_op = 4'd5;
        #1;
        chk("mfhi_rd", rd_data, 32'h0000_1234);
        issue(4'd8, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        chk("mtlo_lo", lo, 32'h0000_5678);
        mdu_op = 4'd6;
        #1;
        chk("mflo_rd", rd_data, 32'h0000_5678);
        mdu_op = 4'd0;
        #1;
        chk("none_rd", rd_data, 32'd0);
        issue(4'd8, 32'h0000_9999, 32'd0, 1'b0, 1'b1);
        chk("mtlo_req_lo", lo, 32'h0000_5678);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        chk("div_req_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("div_req_busy_later", {31'd0, busy}, 32'd0);
        chk("div_req_hi", hi, 32'h0000_1234);
        chk("div_req_lo", lo, 32'h0000_5678);

        // req during RUN does not abort the op in flight.
        expect_op("div_req_mid", 32'd2, 32'hFFFF_FFF2, 10);
        drive(4'd3, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
        idle_in();
        idle_in();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle_in();
        wait_idle("div_req_mid");

        issue(4'd1, 32'd5, 32'd6, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
